// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared hex decoder, per-digit
// anode drive, dead-time gaps, frame-aligned double-buffered value updates.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    lz_en,
  output logic                    ready,
  output logic [3:0]              dec_num,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_DIGITS);
  // Out of reset the GAP state is held for at least one cycle so the
  // anodes stay dark while rst is asserted.
  localparam int GAP_LEN = (BLANK_CYCLES > 0) ? BLANK_CYCLES : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    S_GAP,
    S_SHOW
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pend_q, pend_d;
  logic                    fd_q, fd_d;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    all_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_GAP;
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      fd_q     <= fd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    wrap     = 1'b0;
    unique case (state_q)
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end
      end
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = (BLANK_CYCLES == 0) ? S_SHOW : S_GAP;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
    fd_d = wrap;
    if (wrap && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
    // ready is !pend_q, so a commit and an accept can never coincide
    if (load && !pend_q) begin
      shadow_d = value_in;
      pend_d   = 1'b1;
    end
  end

  always_comb begin
    supp     = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero & (disp_q[4*i +: 4] == 4'h0);
      supp[i]  = all_zero;
    end
  end

  always_comb begin
    an      = '1;
    dec_num = 4'h0;
    blank   = 1'b1;
    if (state_q == S_SHOW) begin
      an[idx_q] = 1'b0;
      dec_num   = disp_q[4*idx_q +: 4];
      blank     = lz_en & supp[idx_q];
    end
  end

  assign ready      = !pend_q;
  assign frame_done = fd_q;

endmodule
